// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO side bus of the write arbiter: request vector, data, grants and FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = fifo_arb_pkg::DEF_WIDTH,
  parameter int NREQ  = fifo_arb_pkg::DEF_NREQ
);

  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_write_data;
  logic [OW-1:0]         owner;
  logic                  busy;

  // master is the arbiter; slave is the requesters plus the downstream FIFO.
  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_en, fifo_write_data, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_en, fifo_write_data, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester with req high, searching upward from last_owner+1 (mod NREQ).
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int OW = $clog2(NREQ);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    valid = 1'b0;
    index = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && req[(int'(last_owner) + i) % NREQ]) begin
        valid = 1'b1;
        index = OW'((int'(last_owner) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter writing one requester's words straight into a FIFO (zero latency, no buffering).
module fifo_wr_arbiter #(
  parameter int WIDTH = fifo_arb_pkg::DEF_WIDTH,
  parameter int NREQ  = fifo_arb_pkg::DEF_NREQ,
  parameter int BURST = fifo_arb_pkg::DEF_BURST
) (
  input logic                clk,
  input logic                reset,
  fifo_wr_arbiter_if.master  bus
);

  localparam int              OW         = $clog2(NREQ);
  localparam int              CW         = $clog2(BURST + 1);
  localparam logic [CW-1:0]   COUNT_LAST = CW'(BURST - 1);
  localparam logic [OW-1:0]   OWNER_INIT = OW'(NREQ - 1);

  // The parameter BURST shadows the enum literal, so states are package-qualified.
  fifo_arb_pkg::state_e state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;

  logic                 pick_valid;
  logic [OW-1:0]        pick_index;
  logic                 accept;
  logic [NREQ-1:0]      gnt;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    accept       = 1'b0;
    gnt          = '0;

    unique case (state_q)
      fifo_arb_pkg::IDLE: begin
        if (pick_valid) begin
          owner_d = pick_index;
          count_d = '0;
          state_d = fifo_arb_pkg::BURST;
        end
      end
      fifo_arb_pkg::BURST: begin
        accept       = bus.req[owner_q] & ~bus.fifo_full;
        gnt[owner_q] = accept;
        // A full FIFO only stalls the tenure; a withdrawn request ends it.
        if (!bus.req[owner_q] || (accept && count_q == COUNT_LAST)) begin
          state_d      = fifo_arb_pkg::IDLE;
          count_d      = '0;
          last_owner_d = owner_q;
        end else if (accept) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = fifo_arb_pkg::IDLE;
    endcase

    if (reset) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values; reset is synchronous here.
    if (reset) begin
      state_q      <= fifo_arb_pkg::IDLE;
      count_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OWNER_INIT;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.gnt             = gnt;
  assign bus.fifo_wr_en      = |gnt;
  assign bus.fifo_write_data = bus.req_data[int'(owner_q)*WIDTH +: WIDTH];
  assign bus.owner           = owner_q;
  assign bus.busy            = (state_q == fifo_arb_pkg::BURST) && !reset;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed cycle table, queued-burst and full-stall sequences, random scoreboard run.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       wr;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] req, input logic full,
                              input logic [3:0] gnt, input logic wr, input logic [1:0] owner,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.full = full;
    v.gnt = gnt; v.wr = wr; v.owner = owner; v.busy = busy;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] model_word(input int idx, input logic [5:0] s);
    return {2'(idx), s};
  endfunction

  initial begin
    logic [7:0] q_words[6];
    int         exp_wr[9];
    int         head;
    logic [5:0] seq[NREQ];
    logic [3:0] seen;
    int         gidx;

    reset         = 1'b1;
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (2) @(posedge clk);

    // rst req full | gnt wr owner busy
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 4'(1 << t), 1, 2'(t), 1);
      add(0, 4'b1111, 0, 4'b0000, 0, 2'(t), 0);
    end
    add(0, 4'b1111, 0, 4'b0001, 1, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b1000, 1, 3, 1);
    add(0, 4'b0001, 0, 4'b0000, 0, 3, 1);
    add(0, 4'b1001, 0, 4'b0000, 0, 3, 0);
    add(0, 4'b1001, 0, 4'b0001, 1, 0, 1);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1001, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b1000, 1, 3, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 3, 1);
    add(0, 4'b0010, 0, 4'b0000, 0, 3, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 4'b0010, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1);
    add(0, 4'b0010, 0, 4'b0000, 0, 1, 0);
    add(0, 4'b0010, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    add(0, 4'b0100, 0, 4'b0000, 0, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 1, 2, 1);
    add(1, 4'b0100, 0, 4'b0000, 0, 2, 0);
    add(0, 4'b0101, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0101, 0, 4'b0001, 1, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset         = vecs[k].rst;
      bus.req       = vecs[k].req;
      bus.fifo_full = vecs[k].full;
      #1;
      check($sformatf("vec%0d_gnt", k),   bus.gnt,        vecs[k].gnt);
      check($sformatf("vec%0d_wr", k),    bus.fifo_wr_en, vecs[k].wr);
      check($sformatf("vec%0d_owner", k), bus.owner,      vecs[k].owner);
      check($sformatf("vec%0d_busy", k),  bus.busy,       vecs[k].busy);
      if (vecs[k].wr)
        check($sformatf("vec%0d_data", k), bus.fifo_write_data, 8'hA0 + 8'(vecs[k].owner));
    end

    // Requester 2 alone with six queued words: 4 writes, bubble, 2 writes, then exit.
    q_words = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
    exp_wr  = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    head    = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.req       = (head < 6) ? 4'b0100 : 4'b0000;
      bus.fifo_full = 1'b0;
      if (head < 6) bus.req_data[2*WIDTH +: WIDTH] = q_words[head];
      #1;
      check($sformatf("q_wr_c%0d", c), bus.fifo_wr_en, exp_wr[c]);
      if (bus.fifo_wr_en && head < 6) begin
        check($sformatf("q_data_%0d", head), bus.fifo_write_data, q_words[head]);
        check($sformatf("q_owner_%0d", head), bus.owner, 2);
        head++;
      end
    end
    check("q_words_written", head, 6);

    // Random requests and full flag against a per-requester word scoreboard.
    for (int i = 0; i < NREQ; i++) seq[i] = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        bus.req[i] = ($urandom_range(0, 9) < 7);
        bus.req_data[i*WIDTH +: WIDTH] = model_word(i, seq[i]);
      end
      bus.fifo_full = ($urandom_range(0, 9) < 3);
      #1;
      check("rnd_onehot", $onehot0(bus.gnt), 1);
      check("rnd_wr_full", bus.fifo_wr_en & bus.fifo_full, 0);
      check("rnd_wr_en", bus.fifo_wr_en, |bus.gnt);
      check("rnd_gnt_req", bus.gnt & ~bus.req, 0);
      if (bus.fifo_wr_en) begin
        gidx = 0;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gidx = i;
        check("rnd_data", bus.fifo_write_data, model_word(gidx, seq[gidx]));
        seq[gidx] = seq[gidx] + 1'b1;
      end
    end

    // Everyone requesting with room in the FIFO: each requester must be served within a bounded window.
    seen = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.req       = 4'b1111;
      bus.fifo_full = 1'b0;
      #1;
      seen = seen | bus.gnt;
    end
    check("live_all_served", seen, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
